cycle_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the five instruction phases: fetch, decode, execute, memory, writeback.
- Drives one-hot stage enables, handles instruction- and data-cache wait states, latches the branch decision during execute, and issues a single-cycle PC load strobe at writeback.
- Replaces the free-running "every 5th clock" PC update with an explicit, stall-aware handshake.
- Sits between the caches, the decode/ALU flags and the PC register.

---
 rtl/cycle_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_cycle_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction sequencer: walks fetch/decode/execute/memory/writeback,
// absorbs cache wait states, and strobes the PC load once per retired instruction.
module cycle_sequencer #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 mem_access,
    input  logic                 halt_instr,
    input  logic                 branchFlag,
    input  logic                 unconditionalBranchFlag,
    input  logic                 zeroFlag,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 if_en,
    output logic                 id_en,
    output logic                 ex_en,
    output logic                 mem_en,
    output logic                 wb_en,
    output logic                 pc_load,
    output logic                 pc_src,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [15:0]          stall_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        HALT,
        FAULT
    } state_t;

    state_t     state;
    state_t     nextState;
    logic [7:0] waitCount;
    logic       waiting;
    logic       timedOut;
    logic       pcSrcReg;

    // A request is stalling when its stage is active and the cache is not ready.
    always_comb begin
        waiting  = ((state == FETCH) && !imem_ready) ||
                   ((state == MEMORY) && mem_access && !dmem_ready);
        timedOut = waiting && (waitCount == 8'(WAIT_LIMIT - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                if (imem_ready) begin
                    nextState = DECODE;
                end else if (timedOut) begin
                    nextState = FAULT;
                end
            end
            DECODE: begin
                nextState = halt_instr ? HALT : EXECUTE;
            end
            EXECUTE: begin
                nextState = MEMORY;
            end
            MEMORY: begin
                if (!mem_access || dmem_ready) begin
                    nextState = WRITEBACK;
                end else if (timedOut) begin
                    nextState = FAULT;
                end
            end
            WRITEBACK: begin
                nextState = FETCH;
            end
            HALT: begin
                nextState = HALT;
            end
            FAULT: begin
                nextState = FAULT;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        if_en    = 1'b0;
        id_en    = 1'b0;
        ex_en    = 1'b0;
        mem_en   = 1'b0;
        wb_en    = 1'b0;
        pc_load  = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state)
            FETCH: begin
                if_en    = 1'b1;
                imem_req = 1'b1;
            end
            DECODE: begin
                id_en = 1'b1;
            end
            EXECUTE: begin
                ex_en = 1'b1;
            end
            MEMORY: begin
                mem_en   = 1'b1;
                dmem_req = mem_access;
            end
            WRITEBACK: begin
                wb_en   = 1'b1;
                pc_load = 1'b1;
            end
            HALT: begin
                halted = 1'b1;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    // The counter restarts on every state change, so each request gets its own budget.
    always_ff @(posedge clock) begin
        if (reset) begin
            waitCount <= 8'd0;
        end else if (nextState != state) begin
            waitCount <= 8'd0;
        end else if (waiting) begin
            waitCount <= waitCount + 8'd1;
        end
    end

    // Branch decision is captured once per instruction and held for the PC register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcSrcReg <= 1'b0;
        end else if (state == EXECUTE) begin
            pcSrcReg <= (zeroFlag & branchFlag) | unconditionalBranchFlag;
        end
    end

    assign pc_src = pcSrcReg;

    always_ff @(posedge clock) begin
        if (reset) begin
            instr_count <= '0;
            stall_count <= 16'd0;
        end else begin
            if (state == WRITEBACK) begin
                instr_count <= instr_count + CNT_WIDTH'(1);
            end
            if (waiting && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Randomised bench for cycle_sequencer: each instruction is planned at the
// transaction level and expanded into a per-cycle stimulus/expectation schedule.
module tb_cycle_sequencer;

    localparam int WAIT_LIMIT = 16;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_DEC   = 2;
    localparam int P_EXE   = 3;
    localparam int P_MEM   = 4;
    localparam int P_WB    = 5;
    localparam int P_HALT  = 6;
    localparam int P_FAULT = 7;

    logic        clock;
    logic        reset;
    logic        start;
    logic        imemReady;
    logic        dmemReady;
    logic        memAccess;
    logic        haltInstr;
    logic        branchFlag;
    logic        uncondFlag;
    logic        zeroFlag;
    logic        imemReq;
    logic        dmemReq;
    logic        ifEn;
    logic        idEn;
    logic        exEn;
    logic        memEn;
    logic        wbEn;
    logic        pcLoad;
    logic        pcSrc;
    logic        halted;
    logic        fault;
    logic [31:0] instrCount;
    logic [15:0] stallCount;

    cycle_sequencer #(
        .WAIT_LIMIT(WAIT_LIMIT),
        .CNT_WIDTH (32)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .imem_ready             (imemReady),
        .dmem_ready             (dmemReady),
        .mem_access             (memAccess),
        .halt_instr             (haltInstr),
        .branchFlag             (branchFlag),
        .unconditionalBranchFlag(uncondFlag),
        .zeroFlag               (zeroFlag),
        .imem_req               (imemReq),
        .dmem_req               (dmemReq),
        .if_en                  (ifEn),
        .id_en                  (idEn),
        .ex_en                  (exEn),
        .mem_en                 (memEn),
        .wb_en                  (wbEn),
        .pc_load                (pcLoad),
        .pc_src                 (pcSrc),
        .halted                 (halted),
        .fault                  (fault),
        .instr_count            (instrCount),
        .stall_count            (stallCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        start;
        logic        imemReady;
        logic        dmemReady;
        logic        memAccess;
        logic        haltInstr;
        logic        branchFlag;
        logic        uncondFlag;
        logic        zeroFlag;
        logic [10:0] expOut;
        logic [31:0] expInstr;
        logic [15:0] expStall;
        logic [2:0]  phase;
    } cycleRec_t;

    cycleRec_t   sched[$];
    logic        mPcSrc;
    logic [31:0] mInstr;
    logic [15:0] mStall;
    int          checks;
    int          errors;
    int          res;

    function automatic string phaseName(logic [2:0] p);
        case (p)
            3'd0:    return "idle";
            3'd1:    return "fetch";
            3'd2:    return "decode";
            3'd3:    return "execute";
            3'd4:    return "memory";
            3'd5:    return "writeback";
            3'd6:    return "halt";
            default: return "fault";
        endcase
    endfunction

    function automatic cycleRec_t randRec();
        cycleRec_t r;
        r = '0;
        r.start      = 1'($urandom);
        r.imemReady  = 1'($urandom);
        r.dmemReady  = 1'($urandom);
        r.memAccess  = 1'($urandom);
        r.haltInstr  = 1'($urandom);
        r.branchFlag = 1'($urandom);
        r.uncondFlag = 1'($urandom);
        r.zeroFlag   = 1'($urandom);
        return r;
    endfunction

    // Expected outputs come from the phase the instruction is in during that cycle.
    function automatic void pushCycle(cycleRec_t rIn, int phase, bit stalled, bit retire);
        cycleRec_t  r;
        logic [4:0] en;
        r  = rIn;
        en = 5'b0;
        if (phase >= P_FETCH && phase <= P_WB) begin
            en = 5'b10000 >> (phase - P_FETCH);
        end
        r.expOut   = {en, phase == P_FETCH, (phase == P_MEM) && r.memAccess,
                      phase == P_WB, mPcSrc, phase == P_HALT, phase == P_FAULT};
        r.expInstr = mInstr;
        r.expStall = mStall;
        r.phase    = 3'(phase);
        sched.push_back(r);
        if (stalled && mStall != 16'hFFFF) mStall = mStall + 16'd1;
        if (retire) mInstr = mInstr + 32'd1;
    endfunction

    function automatic void addIdle(int n, bit withStart);
        cycleRec_t r;
        for (int i = 0; i < n; i++) begin
            r = randRec();
            r.start = 1'b0;
            pushCycle(r, P_IDLE, 0, 0);
        end
        if (withStart) begin
            r = randRec();
            r.start = 1'b1;
            pushCycle(r, P_IDLE, 0, 0);
        end
    endfunction

    function automatic void addSticky(int phase, int n);
        for (int i = 0; i < n; i++) begin
            pushCycle(randRec(), phase, 0, 0);
        end
    endfunction

    // Returns 0 when the instruction retires, otherwise the terminal phase reached.
    function automatic int addInstr(int iWait, bit halt, bit br, bit uncond, bit zero,
                                    bit memAcc, int dWait);
        cycleRec_t r;
        for (int k = 0; k < iWait; k++) begin
            r = randRec();
            r.imemReady = 1'b0;
            pushCycle(r, P_FETCH, 1, 0);
            if (k == WAIT_LIMIT - 1) return P_FAULT;
        end
        r = randRec();
        r.imemReady = 1'b1;
        pushCycle(r, P_FETCH, 0, 0);
        r = randRec();
        r.haltInstr = halt;
        pushCycle(r, P_DEC, 0, 0);
        if (halt) return P_HALT;
        r = randRec();
        r.branchFlag = br;
        r.uncondFlag = uncond;
        r.zeroFlag   = zero;
        pushCycle(r, P_EXE, 0, 0);
        mPcSrc = (zero && br) || uncond;
        if (!memAcc) begin
            r = randRec();
            r.memAccess = 1'b0;
            pushCycle(r, P_MEM, 0, 0);
        end else begin
            for (int k = 0; k < dWait; k++) begin
                r = randRec();
                r.memAccess = 1'b1;
                r.dmemReady = 1'b0;
                pushCycle(r, P_MEM, 1, 0);
                if (k == WAIT_LIMIT - 1) return P_FAULT;
            end
            r = randRec();
            r.memAccess = 1'b1;
            r.dmemReady = 1'b1;
            pushCycle(r, P_MEM, 0, 0);
        end
        pushCycle(randRec(), P_WB, 0, 1);
        return 0;
    endfunction

    task automatic applyStimulus(input cycleRec_t r);
        start      = r.start;
        imemReady  = r.imemReady;
        dmemReady  = r.dmemReady;
        memAccess  = r.memAccess;
        haltInstr  = r.haltInstr;
        branchFlag = r.branchFlag;
        uncondFlag = r.uncondFlag;
        zeroFlag   = r.zeroFlag;
    endtask

    task automatic checkOutput(input cycleRec_t r);
        logic [10:0] obs;
        obs = {ifEn, idEn, exEn, memEn, wbEn, imemReq, dmemReq, pcLoad, pcSrc, halted, fault};
        checks++;
        assert (obs === r.expOut) else begin
            errors++;
            $error("FAIL outputs(%s): got %b want %b", phaseName(r.phase), obs, r.expOut);
        end
        checks++;
        assert (instrCount === r.expInstr) else begin
            errors++;
            $error("FAIL instr_count(%s): got %0d want %0d", phaseName(r.phase), instrCount, r.expInstr);
        end
        checks++;
        assert (stallCount === r.expStall) else begin
            errors++;
            $error("FAIL stall_count(%s): got %0d want %0d", phaseName(r.phase), stallCount, r.expStall);
        end
    endtask

    // Each step starts just after a rising edge and is checked on the falling edge.
    task automatic runSched();
        cycleRec_t r;
        while (sched.size() > 0) begin
            r = sched.pop_front();
            applyStimulus(r);
            @(negedge clock);
            checkOutput(r);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic doReset();
        logic [10:0] obs;
        applyStimulus(randRec());
        start     = 1'b1;
        memAccess = 1'b1;
        dmemReady = 1'b0;
        reset     = 1'b1;
        @(posedge clock);
        #1;
        obs = {ifEn, idEn, exEn, memEn, wbEn, imemReq, dmemReq, pcLoad, pcSrc, halted, fault};
        checks++;
        assert (obs === 11'b0) else begin
            errors++;
            $error("FAIL reset outputs: got %b want %b", obs, 11'b0);
        end
        checks++;
        assert (instrCount === 32'd0 && stallCount === 16'd0) else begin
            errors++;
            $error("FAIL reset counters: got %0d/%0d want 0/0", instrCount, stallCount);
        end
        reset  = 1'b0;
        mPcSrc = 1'b0;
        mInstr = 32'd0;
        mStall = 16'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus('0);
        @(posedge clock);
        #1;

        $display("[TB] zero-wait pipeline");
        doReset();
        addIdle(2, 1);
        for (int i = 0; i < 4; i++) res = addInstr(0, 0, 0, 0, 0, 0, 0);
        runSched();

        $display("[TB] branch decisions");
        res = addInstr(0, 0, 1, 0, 1, 0, 0);
        res = addInstr(0, 0, 1, 0, 0, 0, 0);
        res = addInstr(0, 0, 0, 1, 0, 0, 0);
        res = addInstr(0, 0, 0, 0, 1, 0, 0);
        runSched();

        $display("[TB] fetch and load stalls");
        res = addInstr(3, 0, 0, 0, 0, 1, 2);
        res = addInstr(0, 0, 1, 1, 1, 1, 0);
        runSched();

        $display("[TB] fetch timeout");
        doReset();
        addIdle(1, 1);
        res = addInstr(WAIT_LIMIT - 1, 0, 0, 0, 0, 0, 0);
        res = addInstr(WAIT_LIMIT, 0, 0, 0, 0, 0, 0);
        addSticky(P_FAULT, 5);
        runSched();

        $display("[TB] data timeout");
        doReset();
        addIdle(1, 1);
        res = addInstr(0, 0, 0, 1, 0, 1, WAIT_LIMIT - 1);
        res = addInstr(0, 0, 0, 0, 0, 1, WAIT_LIMIT);
        addSticky(P_FAULT, 4);
        runSched();

        $display("[TB] halt");
        doReset();
        addIdle(0, 1);
        res = addInstr(1, 0, 0, 1, 0, 0, 0);
        res = addInstr(0, 1, 0, 0, 0, 0, 0);
        addSticky(P_HALT, 6);
        runSched();

        $display("[TB] reset during data request");
        doReset();
        addIdle(1, 1);
        res = addInstr(0, 0, 0, 0, 0, 1, 5);
        repeat (4) void'(sched.pop_back());
        runSched();
        doReset();
        addIdle(0, 1);
        res = addInstr(0, 0, 0, 0, 0, 0, 0);
        runSched();

        $display("[TB] random instruction stream");
        doReset();
        addIdle($urandom_range(0, 3), 1);
        for (int i = 0; i < 30; i++) begin
            int iw;
            int dw;
            iw  = ($urandom_range(0, 7) == 0) ? $urandom_range(10, WAIT_LIMIT - 1) : $urandom_range(0, 3);
            dw  = ($urandom_range(0, 7) == 0) ? $urandom_range(10, WAIT_LIMIT - 1) : $urandom_range(0, 3);
            res = addInstr(iw, ($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom),
                           1'($urandom), 1'($urandom), dw);
            if (res != 0) begin
                addSticky(res, 4);
                break;
            end
        end
        runSched();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
